// File: rtl/qspi_rx_fifo_if.sv
// Bundle between the QSPI receive FIFO and its neighbours: the push side (qspi_fsm),
// the pop side (register/bus read) and the status/control signals.
interface qspi_rx_fifo_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic              full;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              empty;
    logic [ADDR_W:0]   level;
    logic [ADDR_W:0]   thresh;
    logic              thresh_hit;
    logic              flush;
    logic              clr_flags;
    logic              overflow;
    logic              underflow;

    // FIFO side
    modport slave (
        input  wr_data, wr_en, rd_en, thresh, flush, clr_flags,
        output full, rd_data, empty, level, thresh_hit, overflow, underflow
    );

    // producer / consumer / controller side
    modport master (
        output wr_data, wr_en, rd_en, thresh, flush, clr_flags,
        input  full, rd_data, empty, level, thresh_hit, overflow, underflow
    );
endinterface

// File: rtl/qspi_rx_fifo.sv
// QSPI receive FIFO: first-word-fall-through buffer behind qspi_fsm with fill level,
// threshold flag and sticky overflow/underflow status.
module qspi_rx_fifo #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic           clk,
    input  logic           reset,
    qspi_rx_fifo_if.slave  fif
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              rd_ok;
    logic              wr_ok;
    logic              ovf_evt;
    logic              udf_evt;
    logic              overflow;
    logic              underflow;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // A pop frees the slot in the same cycle, so a full FIFO still takes a write alongside a read.
    assign rd_ok = fif.rd_en && !empty;
    assign wr_ok = fif.wr_en && (!full || rd_ok);

    // Requests discarded by a flush are not reported as errors.
    assign ovf_evt = !fif.flush && fif.wr_en && !wr_ok;
    assign udf_evt = !fif.flush && fif.rd_en && empty;

    // Storage is not reset; only the pointers define valid contents.
    always_ff @(posedge clk) begin
        if (wr_ok && !fif.flush)
            mem[wptr] <= fif.wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (fif.flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_ok)
                wptr <= wptr + 1'b1;
            if (rd_ok)
                rptr <= rptr + 1'b1;
            if (wr_ok && !rd_ok)
                count <= count + 1'b1;
            else if (rd_ok && !wr_ok)
                count <= count - 1'b1;
        end
    end

    // Set wins over clear so an error coincident with clr_flags stays visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_evt)
                overflow <= 1'b1;
            else if (fif.clr_flags)
                overflow <= 1'b0;
            if (udf_evt)
                underflow <= 1'b1;
            else if (fif.clr_flags)
                underflow <= 1'b0;
        end
    end

    assign fif.full       = full;
    assign fif.empty      = empty;
    assign fif.level      = count;
    assign fif.rd_data    = mem[rptr];
    assign fif.thresh_hit = (fif.thresh != '0) && (count >= fif.thresh);
    assign fif.overflow   = overflow;
    assign fif.underflow  = underflow;
endmodule

// File: tb/tb_qspi_rx_fifo.sv
// Self-checking bench for qspi_rx_fifo: directed vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_qspi_rx_fifo;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    qspi_rx_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) fif ();
    qspi_rx_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (.clk(clk), .reset(reset), .fif(fif));

    int n_checks = 0;
    int n_fail   = 0;

    // reference model
    logic [DATA_W-1:0] mq[$];
    logic              m_ovf, m_udf;

    typedef struct {
        logic        wr, rd, fl, clr;
        logic [31:0] wdata;
        logic [4:0]  thr;
        logic        e_empty, e_full;
        logic [4:0]  e_level;
        logic [31:0] e_rd;
        logic        e_thit, e_ovf, e_udf;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t row(input logic wr, rd, fl, clr, input logic [31:0] wd,
                                 input logic [4:0] thr, input logic ee, ef,
                                 input logic [4:0] el, input logic [31:0] erd,
                                 input logic eth, eo, eu);
        vec_t v;
        v.wr = wr; v.rd = rd; v.fl = fl; v.clr = clr; v.wdata = wd; v.thr = thr;
        v.e_empty = ee; v.e_full = ef; v.e_level = el; v.e_rd = erd;
        v.e_thit = eth; v.e_ovf = eo; v.e_udf = eu;
        return v;
    endfunction

    task automatic model_step();
        bit rd_acc, wr_acc;
        if (fif.flush) begin
            mq.delete();
        end else begin
            rd_acc = fif.rd_en && (mq.size() > 0);
            wr_acc = fif.wr_en && ((mq.size() < DEPTH) || rd_acc);
            if (fif.wr_en && !wr_acc) m_ovf = 1'b1;
            else if (fif.clr_flags)   m_ovf = 1'b0;
            if (fif.rd_en && mq.size() == 0) m_udf = 1'b1;
            else if (fif.clr_flags)          m_udf = 1'b0;
            if (rd_acc) void'(mq.pop_front());
            if (wr_acc) mq.push_back(fif.wr_data);
        end
        if (fif.flush && fif.clr_flags) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end
    endtask

    task automatic compare_model();
        int sz = mq.size();
        check("m_empty", fif.empty, sz == 0);
        check("m_full", fif.full, sz == DEPTH);
        check("m_level", fif.level, sz);
        if (sz > 0) check("m_rd_data", fif.rd_data, mq[0]);
        check("m_thresh_hit", fif.thresh_hit, (fif.thresh != 0) && (sz >= int'(fif.thresh)));
        check("m_overflow", fif.overflow, m_ovf);
        check("m_underflow", fif.underflow, m_udf);
    endtask

    task automatic drive(input logic wr, rd, fl, clr, input logic [31:0] wd);
        fif.wr_en = wr; fif.rd_en = rd; fif.flush = fl; fif.clr_flags = clr; fif.wr_data = wd;
    endtask

    // One clock: model follows the inputs in front of the edge, outputs sampled 1 after it.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_model();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic push(input logic [31:0] wd);
        drive(1'b1, 1'b0, 1'b0, 1'b0, wd);
        cycle();
    endtask

    task automatic pop_expect(input logic [31:0] exp, input string name);
        check(name, fif.rd_data, exp);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        cycle();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        fif.thresh = '0;
        mq.delete(); m_ovf = 1'b0; m_udf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_empty", fif.empty, 1'b1);
        check("rst_full", fif.full, 1'b0);
        check("rst_level", fif.level, 0);
        check("rst_thit", fif.thresh_hit, 1'b0);
        check("rst_ovf", fif.overflow, 1'b0);
        check("rst_udf", fif.underflow, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // directed vectors
        tbl[0]  = row(1,0,0,0, 32'h11111111, 0, 0,0, 1, 32'h11111111, 0,0,0);
        tbl[1]  = row(1,0,0,0, 32'h22222222, 0, 0,0, 2, 32'h11111111, 0,0,0);
        tbl[2]  = row(1,0,0,0, 32'h33333333, 0, 0,0, 3, 32'h11111111, 0,0,0);
        tbl[3]  = row(0,1,0,0, 32'h0,        0, 0,0, 2, 32'h22222222, 0,0,0);
        tbl[4]  = row(0,1,0,0, 32'h0,        0, 0,0, 1, 32'h33333333, 0,0,0);
        tbl[5]  = row(0,1,0,0, 32'h0,        0, 1,0, 0, 32'h0,        0,0,0);
        tbl[6]  = row(0,1,0,0, 32'h0,        0, 1,0, 0, 32'h0,        0,0,1);
        tbl[7]  = row(0,0,0,1, 32'h0,        0, 1,0, 0, 32'h0,        0,0,0);
        tbl[8]  = row(1,0,0,0, 32'h0000000A, 4, 0,0, 1, 32'h0000000A, 0,0,0);
        tbl[9]  = row(1,0,0,0, 32'h0000000B, 4, 0,0, 2, 32'h0000000A, 0,0,0);
        tbl[10] = row(1,0,0,0, 32'h0000000C, 4, 0,0, 3, 32'h0000000A, 0,0,0);
        tbl[11] = row(1,0,0,0, 32'h0000000D, 4, 0,0, 4, 32'h0000000A, 1,0,0);
        tbl[12] = row(1,0,1,0, 32'h12345678, 4, 1,0, 0, 32'h0,        0,0,0);
        tbl[13] = row(1,1,0,0, 32'hCAFEF00D, 4, 0,0, 1, 32'hCAFEF00D, 0,0,1);
        tbl[14] = row(0,0,0,1, 32'h0,        1, 0,0, 1, 32'hCAFEF00D, 1,0,0);
        tbl[15] = row(0,1,0,0, 32'h0,        0, 1,0, 0, 32'h0,        0,0,0);
        for (int i = 0; i < 16; i++) begin
            fif.thresh = tbl[i].thr;
            drive(tbl[i].wr, tbl[i].rd, tbl[i].fl, tbl[i].clr, tbl[i].wdata);
            cycle();
            check($sformatf("v%0d_empty", i), fif.empty, tbl[i].e_empty);
            check($sformatf("v%0d_full", i), fif.full, tbl[i].e_full);
            check($sformatf("v%0d_level", i), fif.level, tbl[i].e_level);
            if (!tbl[i].e_empty) check($sformatf("v%0d_rd", i), fif.rd_data, tbl[i].e_rd);
            check($sformatf("v%0d_thit", i), fif.thresh_hit, tbl[i].e_thit);
            check($sformatf("v%0d_ovf", i), fif.overflow, tbl[i].e_ovf);
            check($sformatf("v%0d_udf", i), fif.underflow, tbl[i].e_udf);
        end
        fif.thresh = '0;

        // fill, overflow, drain in order, clear
        for (int i = 0; i < DEPTH; i++) push(32'(i));
        check("fill_full", fif.full, 1'b1);
        check("fill_level", fif.level, 16);
        push(32'hDEADBEEF);
        check("drop_ovf", fif.overflow, 1'b1);
        check("drop_level", fif.level, 16);
        for (int i = 0; i < DEPTH; i++) pop_expect(32'(i), $sformatf("drain_%0d", i));
        check("drain_empty", fif.empty, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        cycle();
        check("clr_ovf", fif.overflow, 1'b0);

        // simultaneous read+write while full
        for (int i = 0; i < DEPTH; i++) push(32'h100 + 32'(i));
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hA5A5A5A5);
        cycle();
        check("fullrw_level", fif.level, 16);
        check("fullrw_ovf", fif.overflow, 1'b0);
        for (int i = 1; i < DEPTH; i++) pop_expect(32'h100 + 32'(i), $sformatf("fullrw_%0d", i));
        pop_expect(32'hA5A5A5A5, "fullrw_last");
        check("fullrw_empty", fif.empty, 1'b1);

        // error set wins over clr_flags in the same cycle
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        cycle();
        check("setclr_udf", fif.underflow, 1'b1);
        drive(1'b0, 0, 0, 1'b1, 32'h0);
        cycle();
        check("setclr_cleared", fif.underflow, 1'b0);

        // erased-device style quad read: two 0xFFFFFFFF words, then async reset mid-burst
        push(32'hFFFFFFFF);
        repeat (3) cycle();
        push(32'hFFFFFFFF);
        check("qrd_level", fif.level, 2);
        check("qrd_ovf", fif.overflow, 1'b0);
        check("qrd_rd", fif.rd_data, 32'hFFFFFFFF);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("async_level", fif.level, 0);
        check("async_empty", fif.empty, 1'b1);
        mq.delete(); m_ovf = 1'b0; m_udf = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        compare_model();

        // randomized traffic with phases biased toward full and toward empty
        for (int i = 0; i < 3000; i++) begin
            int wp;
            wp = ((i / 300) % 2 == 0) ? 75 : 25;
            if ($urandom_range(0, 49) == 0) fif.thresh = 5'($urandom_range(0, 16));
            if ($urandom_range(0, 99) < 2) begin
                drive(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), $urandom);
            end else begin
                drive(1'($urandom_range(0, 99) < wp), 1'($urandom_range(0, 99) < (100 - wp)),
                      1'b0, 1'($urandom_range(0, 29) == 0), $urandom);
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/qspi_rx_fifo.md
Name: qspi_rx_fifo

Overview:
Receive-data buffer directly downstream of qspi_fsm. It captures 32-bit words pushed by the FSM (rx_wen / rx_data_fifo) and back-pressures the FSM through rx_full. It presents the words to the register/bus side in first-word-fall-through order. It also provides a fill level, a threshold flag, and sticky overflow/underflow error flags for the controller's status register.

Parameters:
- DATA_W, 32, word width; must match the qspi_fsm rx_data_fifo width.
- ADDR_W, 4, pointer width; DEPTH = 2**ADDR_W = 16 entries.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_data  in  DATA_W  word from qspi_fsm rx_data_fifo.
- wr_en  in  1  push strobe from qspi_fsm rx_wen.
- full  out  1  FIFO full; drives qspi_fsm rx_full.
- rd_en  in  1  pop strobe from the bus-side register read.
- rd_data  out  DATA_W  head word (FWFT); valid while empty=0.
- empty  out  1  no words stored.
- level  out  ADDR_W+1  number of stored words, 0..DEPTH.
- thresh  in  ADDR_W+1  threshold for thresh_hit.
- thresh_hit  out  1  high when level >= thresh and thresh != 0.
- flush  in  1  synchronous clear of contents.
- clr_flags  in  1  clears the sticky error flags.
- overflow  out  1  sticky: a write was dropped.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Storage: DEPTH x DATA_W register array. Write pointer and read pointer are each ADDR_W bits wide and wrap modulo DEPTH. Occupancy is tracked by a separate count register of ADDR_W+1 bits.
- Reset (asynchronous, any time, including mid-burst):
  - pointers = 0, count = 0
  - full = 0, empty = 1, level = 0, thresh_hit = 0
  - overflow = 0, underflow = 0
  - rd_data = mem[0]; the array itself is not cleared.
- Flag derivation: full = (count == DEPTH); empty = (count == 0); level = count. All three are combinational from count, so they are valid the cycle after any push or pop.
- Write accept (wr_ok): wr_en && (!full || rd_ok).
  - On accept, mem[wptr] <= wr_data and wptr increments.
  - A write while full with no simultaneous read is dropped and sets overflow on the next edge.
- Read accept (rd_ok): rd_en && !empty.
  - On accept, rptr increments.
  - rd_en while empty changes no state except setting underflow.
- Read data: rd_data = mem[rptr] (FWFT). A word pushed at edge N is visible on rd_data, with empty = 0, after edge N. Read latency is 0: the consumer samples rd_data in the same cycle it asserts rd_en.
- Count update: count += wr_ok - rd_ok.
  - Simultaneous accepted read and write leaves count unchanged.
  - When full, a simultaneous read+write is legal: the head is popped and the new word is written into the freed slot, and count stays at DEPTH.
  - When empty, a simultaneous read+write accepts the write only; underflow sets and count becomes 1.
- Flush: has priority over wr_en and rd_en in the same cycle. Pointers and count go to 0 and the incoming word is discarded. Flush does not affect overflow or underflow.
- Error flags:
  - Flag set has priority over clr_flags in the same cycle, so an error event coincident with a clear remains visible.
  - The flags hold until clr_flags or reset.
- thresh_hit: combinational from level and thresh; forced to 0 when thresh == 0.
- Pointer wrap: after DEPTH accepted writes and reads, the pointers return to 0 with no gap or duplicate word.

Test Plan:
- After reset release, push 0x11111111, 0x22222222, 0x33333333 on consecutive cycles. Required: level=3, empty=0, rd_data=0x11111111. Then pop three times; rd_data shows 0x22222222 and then 0x33333333, and the FIFO ends with empty=1, level=0.
- Push 16 words 0x0..0xF. Required: full=1, level=16. Push 0xDEADBEEF: it is dropped, overflow=1, and popping all 16 yields 0x0..0xF in order. Assert clr_flags: overflow=0.
- With the FIFO full, assert wr_en and rd_en in the same cycle with word 0xA5A5A5A5. Required: level stays 16, overflow stays 0, and 0xA5A5A5A5 is the last of the 16 words read out.
- With the FIFO empty, assert rd_en together with wr_en of 0xCAFEF00D. Required: underflow=1, level=1, rd_data=0xCAFEF00D.
- Set thresh=4 and push 3 words: thresh_hit=0. Push a 4th: thresh_hit=1. Then assert flush together with wr_en: level=0, empty=1, thresh_hit=0.
- Connect the block to qspi_fsm and qspi_device and run a 0xEB quad read with len_bytes=8 from an erased device. Required: two words of 0xFFFFFFFF, level=2, overflow=0. Pulse reset mid-transfer: level=0 and empty=1 take effect immediately, without waiting for a clock edge.
